// File: rtl/pdm_demod_pkg.sv
// Shared types and parameter limits for the multi-channel PDM demodulator.
// Included by pdm_ch_acc and pdm_demod_mc.
package pdm_demod_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam int NUM_CH_MIN   = 1;
  localparam int NUM_CH_MAX   = 8;
  localparam int WIN_LOG2_MIN = 4;
  localparam int WIN_LOG2_MAX = 14;

  function automatic bit cfg_ok(
    input int nc,
    input int wl,
    input int ow
  );
    return (nc >= NUM_CH_MIN) && (nc <= NUM_CH_MAX) &&
           (wl >= WIN_LOG2_MIN) && (wl <= WIN_LOG2_MAX) &&
           (ow >= wl);
  endfunction

endpackage

// File: rtl/pdm_ch_acc.sv
// One PDM channel: ones counter over a window plus scale/saturate of the
// total that includes the current bit.
module pdm_ch_acc
  import pdm_demod_pkg::*;
#(
  parameter int WIN_LOG2 = 11,
  parameter int OUT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             stb,
  input  logic             done,
  input  logic             din,
  output logic [OUT_W-1:0] res
);

  localparam int CW = WIN_LOG2 + 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] tot;

  assign tot = cnt + {{WIN_LOG2{1'b0}}, din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || done) begin
      cnt <= '0;
    end else if (stb) begin
      cnt <= tot;
    end
  end

  // Only a full window of ones sets the top bit; it maps to full scale.
  assign res = tot[WIN_LOG2] ? '1
             : OUT_W'(tot[WIN_LOG2-1:0]) << (OUT_W - WIN_LOG2);

endmodule

// File: rtl/pdm_demod_mc.sv
// Multi-channel PDM demodulator with windowed ones counting.
// Define PDM_DEMOD_STICKY_OVR_EN for a sticky ovr cleared by ovr_clr.
module pdm_demod_mc
  import pdm_demod_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int WIN_LOG2 = 11,
  parameter int OUT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    pdm_stb,
  input  logic [NUM_CH-1:0]       pdm,
  output logic [NUM_CH*OUT_W-1:0] out_data,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic                    ovr
`ifdef PDM_DEMOD_STICKY_OVR_EN
  ,
  input  logic                    ovr_clr
`endif
);

  if (!cfg_ok(NUM_CH, WIN_LOG2, OUT_W)) begin : g_cfg_err
    $error("pdm_demod_mc: illegal NUM_CH/WIN_LOG2/OUT_W");
  end

  localparam logic [WIN_LOG2-1:0] ONE = WIN_LOG2'(1);

  state_t              state;
  state_t              state_nxt;
  logic [WIN_LOG2-1:0] scnt;
  logic                run;
  logic                take;
  logic                done;
  logic                ovr_set;
  logic [OUT_W-1:0]    res [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en)  state_nxt = ACCUM;
      ACCUM:   if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Dropping en in ACCUM discards the partial window that same clock.
  assign run  = (state == ACCUM) && en;
  assign take = run && pdm_stb;
  assign done = take && (scnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt <= '0;
    end else if (!run) begin
      scnt <= '0;
    end else if (take) begin
      scnt <= scnt + ONE;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pdm_ch_acc #(
      .WIN_LOG2 (WIN_LOG2),
      .OUT_W    (OUT_W)
    ) u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (!run),
      .stb   (take),
      .done  (done),
      .din   (pdm[c]),
      .res   (res[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_vld  <= 1'b0;
    end else if (done) begin
      for (int c = 0; c < NUM_CH; c++) begin
        out_data[c*OUT_W +: OUT_W] <= res[c];
      end
      out_vld <= 1'b1;
    end else if (out_vld && out_rdy) begin
      out_vld <= 1'b0;
    end
  end

  assign ovr_set = done && out_vld && !out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr <= 1'b0;
    end else begin
`ifdef PDM_DEMOD_STICKY_OVR_EN
      ovr <= ovr_set || (ovr && !ovr_clr);
`else
      ovr <= ovr_set;
`endif
    end
  end

endmodule

// File: tb/tb_pdm_demod_mc.sv
// Bench for pdm_demod_mc: default and small-window instances, directed
// scenarios plus random traffic against a window-counting model.
module tb_pdm_demod_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en  [2];
  logic        stb [2];
  logic        rdy [2];
  logic [1:0]  pdm_a;
  logic [2:0]  pdm_b;
  logic [31:0] out_a;
  logic [23:0] out_b;
  logic        vld_a, vld_b;
  logic        ovr_a, ovr_b;
`ifdef PDM_DEMOD_STICKY_OVR_EN
  logic        clr [2];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pdm_demod_mc u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en[0]),
    .pdm_stb  (stb[0]),
    .pdm      (pdm_a),
    .out_data (out_a),
    .out_vld  (vld_a),
    .out_rdy  (rdy[0]),
    .ovr      (ovr_a)
`ifdef PDM_DEMOD_STICKY_OVR_EN
    ,
    .ovr_clr  (clr[0])
`endif
  );

  pdm_demod_mc #(
    .NUM_CH   (3),
    .WIN_LOG2 (4),
    .OUT_W    (8)
  ) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en[1]),
    .pdm_stb  (stb[1]),
    .pdm      (pdm_b),
    .out_data (out_b),
    .out_vld  (vld_b),
    .out_rdy  (rdy[1]),
    .ovr      (ovr_b)
`ifdef PDM_DEMOD_STICKY_OVR_EN
    ,
    .ovr_clr  (clr[1])
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Model: count ones per channel over 2**W accepted strobes.
  int          p_w  [2] = '{11, 4};
  int          p_ow [2] = '{16, 8};
  int          p_nc [2] = '{2, 3};
  bit          m_acc [2] = '{0, 0};
  int          m_n   [2] = '{0, 0};
  int          m_hi  [2][8];
  bit          m_vld [2] = '{0, 0};
  bit          m_ovr [2] = '{0, 0};
  logic [63:0] m_data [2] = '{64'd0, 64'd0};
  bit          m_done, m_ovs;
  logic [7:0]  m_bits;
  longint      m_v;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_acc[d] = 0; m_n[d] = 0; m_vld[d] = 0;
        m_ovr[d] = 0; m_data[d] = '0;
        for (int c = 0; c < 8; c++) m_hi[d][c] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_done = 0;
        m_ovs  = 0;
        m_bits = (d == 0) ? {6'b0, pdm_a} : {5'b0, pdm_b};
        if (m_acc[d] && en[d]) begin
          if (stb[d]) begin
            for (int c = 0; c < p_nc[d]; c++) m_hi[d][c] += int'(m_bits[c]);
            m_n[d]++;
            if (m_n[d] == (1 << p_w[d])) m_done = 1;
          end
        end else begin
          m_n[d] = 0;
          for (int c = 0; c < 8; c++) m_hi[d][c] = 0;
        end
        if (m_done) begin
          m_ovs = m_vld[d] && !rdy[d];
          m_data[d] = '0;
          for (int c = 0; c < p_nc[d]; c++) begin
            m_v = longint'(m_hi[d][c]) * (longint'(1) << (p_ow[d] - p_w[d]));
            if (m_v > (longint'(1) << p_ow[d]) - 1)
              m_v = (longint'(1) << p_ow[d]) - 1;
            m_data[d] |= 64'(m_v) << (c * p_ow[d]);
          end
          m_vld[d] = 1;
          m_n[d] = 0;
          for (int c = 0; c < 8; c++) m_hi[d][c] = 0;
        end else if (m_vld[d] && rdy[d]) begin
          m_vld[d] = 0;
        end
`ifdef PDM_DEMOD_STICKY_OVR_EN
        m_ovr[d] = m_ovs || (m_ovr[d] && !clr[d]);
`else
        m_ovr[d] = m_ovs;
`endif
        m_acc[d] = en[d];
      end
    end
  end

  always @(negedge clk) begin
    chk("a_data", 64'(out_a), m_data[0]);
    chk("a_vld", 64'(vld_a), 64'(m_vld[0]));
    chk("a_ovr", 64'(ovr_a), 64'(m_ovr[0]));
    chk("b_data", 64'(out_b), m_data[1]);
    chk("b_vld", 64'(vld_b), 64'(m_vld[1]));
    chk("b_ovr", 64'(ovr_b), 64'(m_ovr[1]));
  end

  task automatic sa(input logic [1:0] b);
    stb[0] = 1'b1;
    pdm_a  = b;
    if (!en[1]) begin
      stb[1] = 1'($urandom);
      pdm_b  = 3'($urandom);
    end
    @(negedge clk);
    stb[0] = 1'b0;
    if (!en[1]) stb[1] = 1'b0;
  endtask

  task automatic sb(input logic [2:0] b);
    stb[1] = 1'b1;
    pdm_b  = b;
    @(negedge clk);
    stb[1] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      en[d] = 0; stb[d] = 0; rdy[d] = 0;
`ifdef PDM_DEMOD_STICKY_OVR_EN
      clr[d] = 0;
`endif
    end
    pdm_a = '0;
    pdm_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_a_data", 64'(out_a), 64'h0);
    chk("rst_b_vld", 64'(vld_b), 64'h0);
    rst_n = 1'b1;

    // Full-scale ch0, silent ch1, strobe every clock.
    rdy[0] = 1'b1;
    en[0]  = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2047; i++) sa(2'b01);
    chk("t1_vld_pre", 64'(vld_a), 64'h0);
    sa(2'b01);
    chk("t1_vld", 64'(vld_a), 64'h1);
    chk("t1_data", 64'(out_a), 64'h0000_FFFF);
    @(negedge clk);
    chk("t1_vld_clr", 64'(vld_a), 64'h0);

    // Small window: alternating, all ones, all zeros.
    rdy[1] = 1'b1;
    en[1]  = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) sb({2'b01, (i % 2 == 0)});
    chk("t2_data", 64'(out_b), 64'h00FF80);
    chk("t2_vld", 64'(vld_b), 64'h1);
    @(negedge clk);
    rdy[1] = 1'b0;

    // Two windows unconsumed.
    for (int i = 0; i < 16; i++) sb(3'b111);
    chk("t3_w1_data", 64'(out_b), 64'hFFFFFF);
    chk("t3_w1_ovr", 64'(ovr_b), 64'h0);
    for (int i = 0; i < 16; i++) sb(3'b000);
    chk("t3_w2_data", 64'(out_b), 64'h0);
    chk("t3_w2_vld", 64'(vld_b), 64'h1);
    chk("t3_w2_ovr", 64'(ovr_b), 64'h1);
    @(negedge clk);
`ifdef PDM_DEMOD_STICKY_OVR_EN
    chk("t3_sticky", 64'(ovr_b), 64'h1);
    clr[1] = 1'b1;
    @(negedge clk);
    clr[1] = 1'b0;
`endif
    chk("t3_ovr_off", 64'(ovr_b), 64'h0);

    // Transfer coincides with the next completion.
    for (int i = 0; i < 15; i++) sb(3'b001);
    rdy[1] = 1'b1;
    sb(3'b001);
    rdy[1] = 1'b0;
    chk("t4_vld", 64'(vld_b), 64'h1);
    chk("t4_ovr", 64'(ovr_b), 64'h0);
    chk("t4_data", 64'(out_b), 64'h0000FF);
    rdy[1] = 1'b1;
    @(negedge clk);
    chk("t4_vld_clr", 64'(vld_b), 64'h0);

    // Partial window dropped by en, then a fresh full window.
    for (int i = 0; i < 1000; i++) sa(2'b11);
    en[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_no_out", 64'(vld_a), 64'h0);
    en[0] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2048; i++) sa(2'b10);
    chk("t5_data", 64'(out_a), 64'hFFFF_0000);
    chk("t5_vld", 64'(vld_a), 64'h1);

    // Asynchronous reset mid-window with a pending result.
    rdy[1] = 1'b0;
    for (int i = 0; i < 16; i++) sb(3'b111);
    for (int i = 0; i < 5; i++) sb(3'b101);
    chk("t6_pend", 64'(vld_b), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", 64'(vld_b), 64'h0);
    chk("t6_rst_data", 64'(out_b), 64'h0);
    chk("t6_rst_ovr", 64'(ovr_b), 64'h0);
    chk("t6_rst_a", 64'(out_a), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) sb(3'b100);
    chk("t6_post", 64'(out_b), 64'hFF0000);
    chk("t6_post_vld", 64'(vld_b), 64'h1);

    // Random traffic.
    for (int i = 0; i < 30000; i++) begin
      stb[0] = ($urandom_range(0, 3) != 0);
      stb[1] = 1'($urandom);
      pdm_a  = 2'($urandom);
      pdm_b  = 3'($urandom);
      rdy[0] = ($urandom_range(0, 9) < 7);
      rdy[1] = ($urandom_range(0, 3) == 0);
`ifdef PDM_DEMOD_STICKY_OVR_EN
      clr[0] = ($urandom_range(0, 7) == 0);
      clr[1] = ($urandom_range(0, 7) == 0);
`endif
      if ($urandom_range(0, 2999) == 0) en[0] = ~en[0];
      if ($urandom_range(0, 199) == 0) en[1] = ~en[1];
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
